pwm_capture: RTL

Receive-side counterpart to the PWM generator. Samples an incoming PWM waveform, measures high time and period between consecutive rising edges, and reports the measured duty value. Reports go out as parallel words and as a serial frame matching the 10-bit serial load path, so a capture can be looped back into a generator or forwarded to another chip. Sits between the external PWM pin and the serial link, in the same clock domain as the generator.

---
 rtl/ppwm_pkg.sv | 17 +
 rtl/pwm_capture_serial_out.sv | 91 +++++++++
 rtl/pwm_capture.sv | 108 ++++++++++
 3 files changed

// File: rtl/ppwm_pkg.sv
// Shared types and defaults for the PWM capture path and its serial sender.
package ppwm_pkg;

    localparam int unsigned DEFAULT_W = 10;

    typedef enum logic [0:0] {
        SYNC,
        MEASURE
    } meas_state_e;

    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA
    } tx_state_e;

endpackage

// File: rtl/pwm_capture_serial_out.sv
// W-bit parallel-to-serial frame sender: start bit 1, then W bits MSB first.
// One pending slot holds the newest word offered while a frame is in flight.
module serial_out
    import ppwm_pkg::*;
#(
    parameter int unsigned W = DEFAULT_W
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load_i,
    input  logic [W-1:0] word_i,
    output logic         data_o,
    output logic         busy_o
);

    localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;

    tx_state_e       state;
    logic [W-1:0]    shreg;
    logic [CW-1:0]   bits_left;
    logic            pend_valid;
    logic [W-1:0]    pend_word;

    // Frame sequencer; data_o and busy_o are registered.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= IDLE;
            shreg      <= '0;
            bits_left  <= '0;
            pend_valid <= 1'b0;
            pend_word  <= '0;
            data_o     <= 1'b0;
            busy_o     <= 1'b0;
        end else begin
            unique case (state)
                IDLE: begin
                    if (load_i) begin
                        state  <= START;
                        shreg  <= word_i;
                        data_o <= 1'b1;
                        busy_o <= 1'b1;
                    end
                end
                START: begin
                    state     <= DATA;
                    data_o    <= shreg[W-1];
                    shreg     <= shreg << 1;
                    bits_left <= CW'(W - 1);
                    if (load_i) begin
                        pend_valid <= 1'b1;
                        pend_word  <= word_i;
                    end
                end
                DATA: begin
                    if (bits_left == '0) begin
                        // Last bit on the line: chain the next word with no gap.
                        if (load_i) begin
                            state      <= START;
                            shreg      <= word_i;
                            data_o     <= 1'b1;
                            pend_valid <= 1'b0;
                        end else if (pend_valid) begin
                            state      <= START;
                            shreg      <= pend_word;
                            data_o     <= 1'b1;
                            pend_valid <= 1'b0;
                        end else begin
                            state  <= IDLE;
                            data_o <= 1'b0;
                            busy_o <= 1'b0;
                        end
                    end else begin
                        data_o    <= shreg[W-1];
                        shreg     <= shreg << 1;
                        bits_left <= bits_left - 1'b1;
                        if (load_i) begin
                            pend_valid <= 1'b1;
                            pend_word  <= word_i;
                        end
                    end
                end
                default: begin
                    state  <= IDLE;
                    data_o <= 1'b0;
                    busy_o <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: rtl/pwm_capture.sv
// PWM capture: measures high time and period between rising edges of pwm_i
// and forwards each measured duty as a serial frame.
module pwm_capture
    import ppwm_pkg::*;
#(
    parameter int unsigned COUNTER_WIDTH = DEFAULT_W
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     pwm_i,
    output logic [COUNTER_WIDTH-1:0] duty_o,
    output logic [COUNTER_WIDTH:0]   period_o,
    output logic                     valid_o,
    output logic                     timeout_o,
    output logic                     data_o,
    output logic                     busy_o
);

    localparam int unsigned W = COUNTER_WIDTH;
    localparam logic [W:0]   PERIOD_FULL = {1'b1, {W{1'b0}}};
    localparam logic [W:0]   PERIOD_ONE  = {{W{1'b0}}, 1'b1};
    localparam logic [W-1:0] HIGH_MAX    = {W{1'b1}};
    localparam logic [W-1:0] HIGH_ONE    = {{(W-1){1'b0}}, 1'b1};

    logic        pwm_meta;
    logic        pwm_s;
    logic        pwm_q;
    logic        rise;
    meas_state_e state;
    logic [W:0]  period_cnt;
    logic [W-1:0] high_cnt;

    // Two-flop synchronizer plus one delay stage for edge detection.
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_meta <= 1'b0;
            pwm_s    <= 1'b0;
            pwm_q    <= 1'b0;
        end else begin
            pwm_meta <= pwm_i;
            pwm_s    <= pwm_meta;
            pwm_q    <= pwm_s;
        end
    end

    assign rise = pwm_s & ~pwm_q;

    // Measurement FSM with registered report outputs.
    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= SYNC;
            period_cnt <= '0;
            high_cnt   <= '0;
            duty_o     <= '0;
            period_o   <= '0;
            valid_o    <= 1'b0;
            timeout_o  <= 1'b0;
        end else begin
            valid_o <= 1'b0;
            unique case (state)
                SYNC: begin
                    // Partial period before the first edge is discarded.
                    if (rise) begin
                        state      <= MEASURE;
                        period_cnt <= PERIOD_ONE;
                        high_cnt   <= HIGH_ONE;
                    end
                end
                MEASURE: begin
                    if (rise) begin
                        duty_o     <= high_cnt;
                        period_o   <= period_cnt;
                        valid_o    <= 1'b1;
                        timeout_o  <= 1'b0;
                        // The edge cycle is high and opens the new period.
                        period_cnt <= PERIOD_ONE;
                        high_cnt   <= HIGH_ONE;
                    end else if (period_cnt == PERIOD_FULL) begin
                        duty_o     <= pwm_s ? HIGH_MAX : '0;
                        period_o   <= PERIOD_FULL;
                        valid_o    <= 1'b1;
                        timeout_o  <= 1'b1;
                        period_cnt <= '0;
                        high_cnt   <= '0;
                    end else begin
                        period_cnt <= period_cnt + 1'b1;
                        if (pwm_s && (high_cnt != HIGH_MAX)) begin
                            high_cnt <= high_cnt + 1'b1;
                        end
                    end
                end
                default: state <= SYNC;
            endcase
        end
    end

    serial_out #(
        .W (W)
    ) u_tx (
        .clk    (clk),
        .rst    (rst),
        .load_i (valid_o),
        .word_i (duty_o),
        .data_o (data_o),
        .busy_o (busy_o)
    );

endmodule
